// File: rtl/ieee_host_source_pkg.sv
// ============================================================================
// Module  : ieee_host_source_pkg
// Brief   : Shared IEEE-488 types: bus wire struct, host source FSM states,
//           status bit indices and the released-bus constant.
// Revision: 1.0
// ============================================================================
`default_nettype none

package ieee_host_source_pkg;

    // Wire levels, active-low: 1 = released.
    typedef struct packed {
        logic [7:0] data;
        logic       atn;
        logic       dav;
        logic       eoi;
        logic       ifc;
        logic       srq;
        logic       ren;
        logic       nrfd;
        logic       ndac;
    } st_ieee_bus;

    localparam st_ieee_bus IEEE_BUS_IDLE = '{
        data: 8'hFF, atn: 1'b1, dav: 1'b1, eoi: 1'b1, ifc: 1'b1,
        srq: 1'b1, ren: 1'b1, nrfd: 1'b1, ndac: 1'b1
    };

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SETTLE   = 3'd1,
        S_CHK      = 3'd2,
        S_SETUP    = 3'd3,
        S_WAIT_RFD = 3'd4,
        S_WAIT_DAC = 3'd5,
        S_END      = 3'd6
    } e_host_src_state;

    localparam int ST_WR_TMO = 0;
    localparam int ST_DNP    = 1;

endpackage

`default_nettype wire

// File: rtl/ieee_host_source_if.sv
// ============================================================================
// Module  : ieee_host_source_if
// Brief   : CPU-side byte request / completion interface of the host source.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface ieee_host_source_if;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] tx_data;
    logic       tx_atn;
    logic       tx_eoi;
    logic       atn_clr;
    logic       done;
    logic [1:0] status;

    modport master (
        output tx_valid, tx_data, tx_atn, tx_eoi, atn_clr,
        input  tx_ready, done, status
    );

    modport slave (
        input  tx_valid, tx_data, tx_atn, tx_eoi, atn_clr,
        output tx_ready, done, status
    );
endinterface

`default_nettype wire

// File: rtl/ieee_host_tick_cnt.sv
// ============================================================================
// Module  : ieee_host_tick_cnt
// Brief   : Loadable down-counter advanced by the ce timebase; flags zero.
// Revision: 1.0
// ============================================================================
`default_nettype none

module ieee_host_tick_cnt #(
    parameter int W = 16
) (
    input  logic         clk_sys,
    input  logic         reset_n,
    input  logic         ce_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (ce_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/ieee_host_source.sv
// ============================================================================
// Module  : ieee_host_source
// Brief   : IEEE-488 controller source handshake (ATN/DAV/EOI) with
//           device-not-present and optional write timeout (IEEE_HOST_TIMEOUT_EN).
// Revision: 1.0
// ============================================================================
`default_nettype none

module ieee_host_source
    import ieee_host_source_pkg::*;
#(
    parameter logic [15:0] TMO_TICKS    = 16'd65000,
    parameter logic [3:0]  SETTLE_TICKS = 4'd4
) (
    input  logic                     clk_sys,
    input  logic                     reset_n,
    input  logic                     ce,
    ieee_host_source_if.slave        hif,
    input  st_ieee_bus               bus_i,
    output st_ieee_bus               bus_o
);

`ifdef IEEE_HOST_TIMEOUT_EN
    localparam int CW = ($bits(TMO_TICKS) > $bits(SETTLE_TICKS)) ?
                        $bits(TMO_TICKS) : $bits(SETTLE_TICKS);
`else
    localparam int CW = $bits(SETTLE_TICKS);
`endif

    e_host_src_state state_q, state_d;
    logic [7:0]      data_q, data_d;
    logic            atn_q, atn_d;
    logic            eoi_q, eoi_d;
    logic            drive_q, drive_d;
    logic            dav_q, dav_d;
    logic            eoi_act_q, eoi_act_d;
    logic [1:0]      status_q, status_d;
    logic            done_q, done_d;
    logic            finish;

    logic            cnt_load;
    logic [CW-1:0]   cnt_val;
    logic            cnt_zero;

    ieee_host_tick_cnt #(
        .W (CW)
    ) u_tick (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .ce_i       (ce),
        .load_i     (cnt_load),
        .load_val_i (cnt_val),
        .zero_o     (cnt_zero)
    );

    // END is folded into the transition back to IDLE so that done and
    // tx_ready rise together the cycle after the terminating condition.
    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        atn_d     = atn_q;
        eoi_d     = eoi_q;
        drive_d   = drive_q;
        dav_d     = dav_q;
        eoi_act_d = eoi_act_q;
        status_d  = status_q;
        done_d    = 1'b0;
        finish    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (hif.tx_valid) begin
                    data_d   = hif.tx_data;
                    atn_d    = hif.tx_atn;
                    eoi_d    = hif.tx_eoi & ~hif.tx_atn;
                    status_d = '0;
                    state_d  = (hif.tx_atn != atn_q) ? S_SETTLE : S_CHK;
                end else if (hif.atn_clr) begin
                    atn_d = 1'b0;
                end
            end
            S_SETTLE: begin
                if (cnt_zero) state_d = S_CHK;
            end
            S_CHK: begin
                if (bus_i.nrfd && bus_i.ndac) begin
                    status_d[ST_DNP] = 1'b1;
                    finish           = 1'b1;
                end else begin
                    drive_d = 1'b1;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                if (cnt_zero) state_d = S_WAIT_RFD;
            end
            S_WAIT_RFD: begin
                if (bus_i.nrfd) begin
                    dav_d     = 1'b1;
                    eoi_act_d = eoi_q;
                    state_d   = S_WAIT_DAC;
                end
`ifdef IEEE_HOST_TIMEOUT_EN
                else if (cnt_zero) begin
                    status_d[ST_WR_TMO] = 1'b1;
                    finish              = 1'b1;
                end
`endif
            end
            S_WAIT_DAC: begin
                if (bus_i.ndac) begin
                    finish = 1'b1;
                end
`ifdef IEEE_HOST_TIMEOUT_EN
                else if (cnt_zero) begin
                    status_d[ST_WR_TMO] = 1'b1;
                    finish              = 1'b1;
                end
`endif
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (finish) begin
            state_d   = S_IDLE;
            drive_d   = 1'b0;
            dav_d     = 1'b0;
            eoi_act_d = 1'b0;
            done_d    = 1'b1;
        end
    end

    // One counter serves every timed state; it is reloaded on each entry.
    always_comb begin
        cnt_val  = CW'(SETTLE_TICKS);
        cnt_load = 1'b0;
        if (state_d != state_q) begin
            case (state_d)
                S_SETTLE, S_SETUP: cnt_load = 1'b1;
`ifdef IEEE_HOST_TIMEOUT_EN
                S_WAIT_RFD, S_WAIT_DAC: begin
                    cnt_load = 1'b1;
                    cnt_val  = CW'(TMO_TICKS);
                end
`endif
                default: cnt_load = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            data_q    <= '0;
            atn_q     <= 1'b0;
            eoi_q     <= 1'b0;
            drive_q   <= 1'b0;
            dav_q     <= 1'b0;
            eoi_act_q <= 1'b0;
            status_q  <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            atn_q     <= atn_d;
            eoi_q     <= eoi_d;
            drive_q   <= drive_d;
            dav_q     <= dav_d;
            eoi_act_q <= eoi_act_d;
            status_q  <= status_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        bus_o      = IEEE_BUS_IDLE;
        bus_o.data = drive_q ? ~data_q : 8'hFF;
        bus_o.atn  = ~atn_q;
        bus_o.dav  = ~dav_q;
        bus_o.eoi  = ~eoi_act_q;
    end

    assign hif.tx_ready = (state_q == S_IDLE);
    assign hif.done     = done_q;
    assign hif.status   = status_q;

endmodule

`default_nettype wire

// File: tb/tb_ieee_host_source.sv
// ============================================================================
// Module  : tb_ieee_host_source
// Brief   : Scoreboard bench for ieee_host_source with a behavioural acceptor.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_ieee_host_source;
    import ieee_host_source_pkg::*;

    logic       clk_sys = 1'b0;
    logic       reset_n = 1'b0;
    logic       ce      = 1'b0;
    st_ieee_bus bus_i;
    st_ieee_bus bus_o;

    ieee_host_source_if hif ();

    ieee_host_source dut (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .ce      (ce),
        .hif     (hif),
        .bus_i   (bus_i),
        .bus_o   (bus_o)
    );

    always #5 clk_sys = ~clk_sys;

    int ce_per = 3;
    int ce_cnt = 0;
    initial begin
        forever begin
            @(posedge clk_sys);
            #1;
            if (ce_cnt + 1 >= ce_per) begin
                ce     = 1'b1;
                ce_cnt = 0;
            end else begin
                ce     = 1'b0;
                ce_cnt = ce_cnt + 1;
            end
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", nm, act, exp);
        end
    endtask

    // Acceptor model: 0 absent, 1 normal, 2 hold NRFD low, 3 hold NDAC low
    localparam int L_ABSENT = 0, L_NORMAL = 1, L_HOLD_RFD = 2, L_HOLD_NDAC = 3;
    int         lmode      = L_ABSENT;
    logic       l_nrfd     = 1'b1;
    logic       l_ndac     = 1'b1;
    logic       prev_dav   = 1'b1;
    int         dav_falls  = 0;
    int         data_ticks = 0;
    int         eoi_viol   = 0;
    logic [7:0] cap_byte   = 8'h00;
    logic       cap_atn    = 1'b0;
    logic       cap_eoi    = 1'b0;

    always_comb begin
        bus_i      = bus_o;
        bus_i.nrfd = bus_o.nrfd & l_nrfd;
        bus_i.ndac = bus_o.ndac & l_ndac;
    end

    always @(negedge clk_sys) begin
        if (bus_o.eoi == 1'b0 && bus_o.dav == 1'b1) eoi_viol++;
        if (prev_dav && !bus_o.dav) begin
            dav_falls++;
            cap_byte = ~bus_o.data;
            cap_atn  = ~bus_o.atn;
            cap_eoi  = ~bus_o.eoi;
            chk("setup_ticks_ge4", 32'(data_ticks >= 4), 32'd1);
            if (lmode == L_NORMAL) begin
                l_nrfd = 1'b0;
                l_ndac = 1'b1;
            end else if (lmode == L_HOLD_NDAC) begin
                l_nrfd = 1'b0;
            end
        end else if (!prev_dav && bus_o.dav) begin
            if (lmode == L_NORMAL || lmode == L_HOLD_NDAC) begin
                l_nrfd = 1'b1;
                l_ndac = 1'b0;
            end
        end
        prev_dav = bus_o.dav;
        if (bus_o.data == 8'hFF) data_ticks = 0;
        else if (ce)             data_ticks = data_ticks + 1;
    end

    typedef struct {
        logic [1:0] status;
        logic       has_byte;
        logic [7:0] byte_v;
        logic       atn_at_dav;
        logic       eoi_at_dav;
        logic       atn_wire_after;
        int         dav_total;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   done_cnt = 0;

    task automatic push_exp(input logic [1:0] st, input logic hb, input logic [7:0] b,
                            input logic aa, input logic ea, input logic aw, input int df);
        exp_t e;
        e.status = st; e.has_byte = hb; e.byte_v = b;
        e.atn_at_dav = aa; e.eoi_at_dav = ea; e.atn_wire_after = aw; e.dav_total = df;
        sb.push_back(e);
    endtask

    always @(negedge clk_sys) begin
        if (reset_n && hif.done === 1'b1) begin
            done_cnt++;
            chk("ready_with_done", 32'(hif.tx_ready), 32'd1);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: actual done with empty queue required no done");
            end else begin
                mon_e = sb.pop_front();
                chk("status", 32'(hif.status), 32'(mon_e.status));
                chk("atn_wire", 32'(bus_o.atn), 32'(mon_e.atn_wire_after));
                chk("dav_count", 32'(dav_falls), 32'(mon_e.dav_total));
                if (mon_e.has_byte) begin
                    chk("rx_byte", 32'(cap_byte), 32'(mon_e.byte_v));
                    chk("rx_atn", 32'(cap_atn), 32'(mon_e.atn_at_dav));
                    chk("rx_eoi", 32'(cap_eoi), 32'(mon_e.eoi_at_dav));
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic atn, input logic eoi, input logic clr);
        int n = 0;
        while (hif.tx_ready !== 1'b1 && n < 200) begin
            cyc(1);
            n++;
        end
        chk("ready_before_send", 32'(hif.tx_ready), 32'd1);
        hif.tx_valid = 1'b1;
        hif.tx_data  = d;
        hif.tx_atn   = atn;
        hif.tx_eoi   = eoi;
        hif.atn_clr  = clr;
        cyc(1);
        hif.tx_valid = 1'b0;
        hif.atn_clr  = 1'b0;
        chk("ready_drop", 32'(hif.tx_ready), 32'd0);
    endtask

    task automatic wait_done(input int budget);
        int n0 = done_cnt;
        int n  = 0;
        while (done_cnt == n0 && n < budget) begin
            cyc(1);
            n++;
        end
        checks++;
        if (done_cnt == n0) begin
            errors++;
            $display("FAIL done_timeout: actual no done in %0d cycles required done", budget);
        end
    endtask

    task automatic set_mode(input int m);
        lmode = m;
        case (m)
            L_ABSENT:   begin l_nrfd = 1'b1; l_ndac = 1'b1; end
            L_HOLD_RFD: begin l_nrfd = 1'b0; l_ndac = 1'b0; end
            default:    begin l_nrfd = 1'b1; l_ndac = 1'b0; end
        endcase
    endtask

    int d0;
    int n;

    initial begin
        hif.tx_valid = 1'b0;
        hif.tx_data  = 8'h00;
        hif.tx_atn   = 1'b0;
        hif.tx_eoi   = 1'b0;
        hif.atn_clr  = 1'b0;

        // Reset values
        cyc(3);
        chk("rst_ready", 32'(hif.tx_ready), 32'd1);
        chk("rst_done", 32'(hif.done), 32'd0);
        chk("rst_status", 32'(hif.status), 32'd0);
        chk("rst_bus", 32'(bus_o), 32'(IEEE_BUS_IDLE));
        reset_n = 1'b1;
        cyc(2);

        // No device: settle, then device-not-present, ATN stays asserted
        set_mode(L_ABSENT);
        push_exp(2'b10, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 0);
        send(8'h28, 1'b1, 1'b0, 1'b0);
        wait_done(500);

        // Listener: command then two data bytes, last tagged EOI
        set_mode(L_NORMAL);
        cyc(2);
        push_exp(2'b00, 1'b1, 8'h28, 1'b1, 1'b0, 1'b0, 1);
        send(8'h28, 1'b1, 1'b0, 1'b0);
        wait_done(500);
        cyc(2);
        push_exp(2'b00, 1'b1, 8'h41, 1'b0, 1'b0, 1'b1, 2);
        send(8'h41, 1'b0, 1'b0, 1'b0);
        wait_done(500);
        cyc(2);
        push_exp(2'b00, 1'b1, 8'h42, 1'b0, 1'b1, 1'b1, 3);
        send(8'h42, 1'b0, 1'b1, 1'b0);
        wait_done(500);
        cyc(2);

        // Held ATN released by atn_clr while idle, without done
        push_exp(2'b00, 1'b1, 8'h3F, 1'b1, 1'b0, 1'b0, 4);
        send(8'h3F, 1'b1, 1'b0, 1'b0);
        wait_done(500);
        cyc(2);
        d0 = done_cnt;
        chk("atn_held", 32'(bus_o.atn), 32'd0);
        hif.atn_clr = 1'b1;
        cyc(1);
        hif.atn_clr = 1'b0;
        chk("atn_cleared", 32'(bus_o.atn), 32'd1);
        cyc(10);
        chk("atn_clr_no_done", 32'(done_cnt), 32'(d0));

        // Byte wins over atn_clr; request during WAIT_RFD ignored
        set_mode(L_HOLD_RFD);
        d0 = done_cnt;
        push_exp(2'b00, 1'b1, 8'h77, 1'b1, 1'b0, 1'b0, 5);
        send(8'h77, 1'b1, 1'b0, 1'b1);
        cyc(40);
        hif.tx_valid = 1'b1;
        hif.tx_data  = 8'hEE;
        hif.tx_atn   = 1'b0;
        cyc(5);
        chk("busy_ready_low", 32'(hif.tx_ready), 32'd0);
        hif.tx_valid = 1'b0;
        set_mode(L_NORMAL);
        wait_done(500);
        cyc(50);
        chk("single_done", 32'(done_cnt - d0), 32'd1);
        chk("single_dav", 32'(dav_falls), 32'd5);

        // Stuck NRFD
        ce_per = 1;
        set_mode(L_HOLD_RFD);
        d0 = done_cnt;
`ifdef IEEE_HOST_TIMEOUT_EN
        push_exp(2'b01, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 5);
        send(8'h55, 1'b0, 1'b0, 1'b0);
        wait_done(70000);
        chk("tmo_bus_released", 32'(bus_o), 32'(IEEE_BUS_IDLE));
`else
        send(8'h55, 1'b0, 1'b0, 1'b0);
        cyc(70000);
        chk("stuck_no_done", 32'(done_cnt), 32'(d0));
        chk("stuck_busy", 32'(hif.tx_ready), 32'd0);
        chk("stuck_dav_high", 32'(bus_o.dav), 32'd1);
        chk("stuck_data", 32'(bus_o.data), 32'hAA);
`endif
        reset_n = 1'b0;
        cyc(2);
        reset_n = 1'b1;
        ce_per  = 3;
        cyc(2);

        // Asynchronous reset while DAV is low in WAIT_DAC
        set_mode(L_HOLD_NDAC);
        cyc(2);
        d0 = done_cnt;
        send(8'h99, 1'b1, 1'b0, 1'b0);
        n = 0;
        while (bus_o.dav !== 1'b0 && n < 300) begin
            cyc(1);
            n++;
        end
        cyc(3);
        chk("dav_low_pre_reset", 32'(bus_o.dav), 32'd0);
        chk("atn_low_pre_reset", 32'(bus_o.atn), 32'd0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_bus", 32'(bus_o), 32'(IEEE_BUS_IDLE));
        chk("async_rst_ready", 32'(hif.tx_ready), 32'd1);
        cyc(2);
        reset_n = 1'b1;
        set_mode(L_NORMAL);
        cyc(5);
        chk("rst_no_done", 32'(done_cnt), 32'(d0));
        chk("eoi_only_with_dav", 32'(eoi_viol), 32'd0);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ieee_host_source.md
# ieee_host_source

Controller-side IEEE-488 source-handshake engine for the PET host: takes command bytes (under ATN) and data bytes (optionally tagged EOI) from the CPU-side interface and clocks them onto the bus with the DAV/NRFD/NDAC three-wire handshake. It is the initiator counterpart to the `ieeedrv_drv` acceptor. It drives an `st_ieee_bus` that is wired-ANDed with the drive outputs. It also reports device-not-present and handshake timeout status the way the PET kernal ST byte expects.

## Interface
Parameters:
- `TMO_TICKS`, default 16'd65000: `ce` ticks allowed in each wait state before timeout (≈65 ms at 1 MHz).
- `SETTLE_TICKS`, default 4'd4: `ce` ticks after any ATN change and after data setup.

Ports:
- `clk_sys`  in  1  system clock.
- `reset_n`  in  1  **asynchronous, active-low** reset.
- `ce`  in  1  1 MHz timebase enable, one `clk_sys` wide.
- `tx_valid`  in  1  byte request.
- `tx_ready`  out  1  engine idle, can accept.
- `tx_data`  in  8  byte, true polarity.
- `tx_atn`  in  1  byte is a command; ATN asserted.
- `tx_eoi`  in  1  last data byte; EOI asserted with DAV. Ignored when `tx_atn`=1.
- `atn_clr`  in  1  pulse; releases a held ATN while idle.
- `done`  out  1  one-cycle pulse at end of each transfer.
- `status`  out  2  bit0 = write timeout, bit1 = device not present. Sticky until the next accept.
- `bus_i`  in  st_ieee_bus  bus levels, already synchronised to `clk_sys`.
- `bus_o`  out  st_ieee_bus  wire levels; 1 = released.

## Operation
- Wire levels are active-low. `bus_o.data` = ~byte while driving, 8'hFF otherwise. `srq`, `ren`, `ifc`, `nrfd` and `ndac` are always 1.
- ATN register: set on accepting a byte with `tx_atn`=1. Cleared on accepting a byte with `tx_atn`=0, or on `atn_clr` while in IDLE. ATN is held across consecutive command bytes.
- States:
  - IDLE: `tx_ready`=1. On accept, latch data/atn/eoi and clear `status`. If the ATN level changes, go to SETTLE; otherwise go to CHK.
  - SETTLE: count `SETTLE_TICKS` `ce` ticks, then go to CHK.
  - CHK: if `bus_i.nrfd`=1 and `bus_i.ndac`=1, set `status[1]` and go to END. Otherwise drive data and go to SETUP.
  - SETUP: count `SETTLE_TICKS` `ce` ticks, then go to WAIT_RFD.
  - WAIT_RFD: wait for `bus_i.nrfd`=1, then assert `dav`=0 (and `eoi`=0 if tagged) and go to WAIT_DAC.
  - WAIT_DAC: wait for `bus_i.ndac`=1, then go to END.
  - END: release dav/eoi/data, pulse `done`, return to IDLE. ATN keeps its register value.
- Timeout counter: reloaded on entry to WAIT_RFD and WAIT_DAC, decremented on `ce`. At 0, set `status[0]` and go to END.
- `tx_valid` outside IDLE is ignored. `atn_clr` outside IDLE is ignored.
- Reset mid-transfer: all lines release immediately and the state returns to IDLE.

## Timing
- Reset values:
  - `tx_ready`=1, `done`=0, `status`=0.
  - `bus_o` = all 1s, data = 8'hFF.
  - ATN register = 0 (ATN released), state = IDLE.
- Accept → `tx_ready` low on the next `clk_sys` edge.
- `done` is asserted the cycle after the condition that ends the wait is seen. `tx_ready` returns high in the same cycle as `done`.
- DAV falls ≥ `SETTLE_TICKS` `ce` ticks after data is valid. DAV and data release together.
- Simultaneous `tx_valid` and `atn_clr` in IDLE: the byte wins and `atn_clr` is dropped.

## Configuration
- `IEEE_HOST_TIMEOUT_EN` defined: the timeout counter and `status[0]` operate as described.
- Undefined: WAIT_RFD and WAIT_DAC wait indefinitely, `status[0]` is tied to 0, and the counter is not synthesised. The device-not-present check is always present.

## Structure
- The shared IEEE package, next to `st_ieee_bus`, holds:
  - state enum `e_host_src_state`;
  - status bit indices `ST_WR_TMO`=0 and `ST_DNP`=1;
  - the released-bus constant `IEEE_BUS_IDLE`.
- One sub-module, `ieee_host_tick_cnt`: a loadable down-counter gated by `ce` that flags zero. It is shared by the SETTLE, SETUP and timeout uses.

## Test plan
- **Command with ATN:** no device (nrfd=ndac=1). Send 8'h28 with `tx_atn`=1 → after 4 ticks, `status`=2'b10, `done` pulses, no DAV edge, ATN still 0.
- **Listener model:** send 8'h28 under ATN, then 8'h41 with `tx_eoi`=0, then 8'h42 with `tx_eoi`=1 → listener captures 28,41,42. ATN released before the 41 DAV. EOI is low only during the 42 DAV. `status`=0.
- **Stuck NRFD:** listener holds nrfd=0. With `IEEE_HOST_TIMEOUT_EN` → `status`=2'b01 after 65000 ticks, all lines released. Without it → still waiting at 70000 ticks.
- **Reset in WAIT_DAC:** pulse `reset_n`=0 while DAV is low → DAV, EOI, ATN and data release asynchronously, and `tx_ready`=1.
- **ATN release:** send 8'h3F under ATN, then pulse `atn_clr` while idle → ATN goes 1 on the next edge, with no `done` pulse.
- **Ignored request:** assert `tx_valid` during WAIT_RFD → no second transfer, exactly one `done`.
